mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 35 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: bus widths, default read
// latency and the sequencer state encoding.
package mem_arb_pkg;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 8;
  localparam int BANK_W     = 2;
  localparam int RD_LAT_DEF = 2;
  localparam int CNT_W      = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CMD   = 2'd1;
  localparam logic [1:0] ST_RWAIT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way request picker with a last-winner pointer (round-robin).
// Defining MEM_ARBITER_FIXED_PRIO_EN makes port 0 always win and drops the pointer.
module rr_arb2
  import mem_arb_pkg::*;
(
`ifndef MEM_ARBITER_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
`endif
  input  logic [1:0] req,
  output logic       pick,
  output logic       pick_valid
);

  assign pick_valid = |req;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  assign pick = ~req[0];
`else
  logic last;

  always_comb begin
    pick = req[1];
    if (&req) pick = ~last;
  end

  // Reset value 1 makes port 0 the favoured side of the first contention.
  always_ff @(posedge clk) begin
    if (rst)         last <= 1'b1;
    else if (accept) last <= pick;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single synchronous memory with RD_LAT read latency.
// Arbitration is round-robin unless MEM_ARBITER_FIXED_PRIO_EN is defined (port 0 first).
//
// state | meaning
// IDLE  | waiting for a request; winner's command is latched on the way out
// CMD   | command driven to memory for one cycle, grant pulse to the winner
// RWAIT | read in flight, RD_LAT-1 cycles, chip still enabled
// DONE  | read data captured at the end of this cycle, rvalid follows
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_cen,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  logic [1:0]       state;
  logic             owner;
  logic             we_q;
  logic [CNT_W-1:0] cnt;
  logic             pick;
  logic             pick_valid;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  rr_arb2 u_arb (
    .req        ({req1, req0}),
    .pick       (pick),
    .pick_valid (pick_valid)
  );
`else
  logic accept;
  assign accept = (state == ST_IDLE) && pick_valid;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .req        ({req1, req0}),
    .pick       (pick),
    .pick_valid (pick_valid)
  );
`endif

  // mem_add/mem_din double as the command latch, so they hold outside CMD/RWAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner   <= 1'b0;
      we_q    <= 1'b0;
      cnt     <= '0;
      mem_add <= '0;
      mem_din <= '0;
      rdata   <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner   <= pick;
            we_q    <= pick ? we1 : we0;
            mem_add <= pick ? addr1 : addr0;
            mem_din <= pick ? wdata1 : wdata0;
            state   <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (we_q) begin
            state <= ST_IDLE;
          end else if (RD_LAT == 1) begin
            state <= ST_DONE;
          end else begin
            cnt   <= CNT_W'(RD_LAT - 1);
            state <= ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          if (cnt == CNT_W'(1)) state <= ST_DONE;
          else                  cnt   <= cnt - CNT_W'(1);
        end
        default: begin
          rdata   <= mem_dout;
          rvalid0 <= ~owner;
          rvalid1 <= owner;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt0    = (state == ST_CMD) && !owner;
  assign gnt1    = (state == ST_CMD) && owner;
  assign mem_rd  = (state == ST_CMD) && !we_q;
  assign mem_wr  = (state == ST_CMD) && we_q;
  assign mem_cen = !((state == ST_CMD) || (state == ST_RWAIT));
  assign busy    = (state != ST_IDLE);

endmodule
